// File: rtl/cnn_div_seq_24s_14s.sv
// Sequential signed divider: restoring shift-subtract on operand magnitudes,
// fixed 26-cycle latency, quotient saturation and divide-by-zero flagging.
module cnn_div_seq_24s_14s #(
    parameter int ID         = 1,
    parameter int DIVIDEND_W = 24,
    parameter int DIVISOR_W  = 14
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] din0,
    input  logic [DIVISOR_W-1:0]  din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quot,
    output logic [DIVISOR_W-1:0]  rem,
    output logic                  dz,
    output logic                  ovf
);

    localparam int unsigned QW = DIVIDEND_W;
    localparam int unsigned RW = DIVISOR_W;
    localparam int unsigned AW = QW + 1;
    localparam int unsigned BW = RW + 1;

    localparam logic [QW-1:0] QMAX = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0] QMIN = {1'b1, {(QW-1){1'b0}}};

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    if (ID < 0 || DIVIDEND_W < 2 || DIVISOR_W < 2) begin : g_param_chk
        $error("cnn_div_seq_24s_14s: illegal parameter value");
    end

    logic [1:0]    state, state_nxt;
    logic [QW-1:0] cnt, cnt_nxt;
    logic [QW-1:0] dq, dq_nxt;
    logic [BW-1:0] pr, pr_nxt;
    logic [BW-1:0] bm, bm_nxt;
    logic          s0, s0_nxt;
    logic          s1, s1_nxt;
    logic          zd, zd_nxt;
    logic          in_ready_nxt, out_valid_nxt;
    logic [QW-1:0] quot_nxt;
    logic [RW-1:0] rem_nxt;
    logic          dz_nxt, ovf_nxt;

    // One bit wider than the operands so the most negative values negate cleanly
    logic [AW-1:0] a_ext, a_mag;
    logic [BW-1:0] b_ext, b_mag;
    logic [BW:0]   trial, diff;

    assign a_ext = {din0[QW-1], din0};
    assign a_mag = din0[QW-1] ? AW'(-a_ext) : a_ext;
    assign b_ext = {din1[RW-1], din1};
    assign b_mag = din1[RW-1] ? BW'(-b_ext) : b_ext;
    assign trial = {pr, dq[QW-1]};
    assign diff  = trial - {1'b0, bm};

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            dq        <= '0;
            pr        <= '0;
            bm        <= '0;
            s0        <= 1'b0;
            s1        <= 1'b0;
            zd        <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quot      <= '0;
            rem       <= '0;
            dz        <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            dq        <= dq_nxt;
            pr        <= pr_nxt;
            bm        <= bm_nxt;
            s0        <= s0_nxt;
            s1        <= s1_nxt;
            zd        <= zd_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            quot      <= quot_nxt;
            rem       <= rem_nxt;
            dz        <= dz_nxt;
            ovf       <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dq_nxt    = dq;
        pr_nxt    = pr;
        bm_nxt    = bm;
        s0_nxt    = s0;
        s1_nxt    = s1;
        zd_nxt    = zd;
        quot_nxt  = quot;
        rem_nxt   = rem;
        dz_nxt    = dz;
        ovf_nxt   = ovf;

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    dq_nxt    = QW'(a_mag);
                    bm_nxt    = b_mag;
                    pr_nxt    = '0;
                    s0_nxt    = din0[QW-1];
                    s1_nxt    = din1[RW-1];
                    zd_nxt    = (din1 == '0);
                    cnt_nxt   = QW'(1);
                    state_nxt = CALC;
                end
            end
            CALC: begin
                // dq shifts dividend bits out the top and quotient bits in the bottom
                if (trial >= {1'b0, bm}) begin
                    pr_nxt = BW'(diff);
                    dq_nxt = {dq[QW-2:0], 1'b1};
                end else begin
                    pr_nxt = BW'(trial);
                    dq_nxt = {dq[QW-2:0], 1'b0};
                end
                cnt_nxt = {cnt[QW-2:0], 1'b0};
                if (cnt[QW-1]) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                if (zd) begin
                    quot_nxt = s0 ? QMIN : QMAX;
                    rem_nxt  = '0;
                    dz_nxt   = 1'b1;
                    ovf_nxt  = 1'b0;
                end else if (!(s0 ^ s1) && dq[QW-1]) begin
                    // only a positive quotient of 2^(QW-1) can get here
                    quot_nxt = QMAX;
                    rem_nxt  = '0;
                    dz_nxt   = 1'b0;
                    ovf_nxt  = 1'b1;
                end else begin
                    quot_nxt = (s0 ^ s1) ? QW'(-dq) : dq;
                    rem_nxt  = s0 ? RW'(-pr) : RW'(pr);
                    dz_nxt   = 1'b0;
                    ovf_nxt  = 1'b0;
                end
                state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        in_ready_nxt  = (state_nxt == IDLE);
        out_valid_nxt = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_cnn_div_seq_24s_14s.sv
// Scoreboard bench for cnn_div_seq_24s_14s: driver pushes reference results,
// monitor pops and checks values, latency, hold stability and handshake.
module tb_cnn_div_seq_24s_14s;

    localparam int N_RAND  = 1500;
    localparam int LATENCY = 26;

    typedef struct {
        logic [23:0] q;
        logic [13:0] r;
        logic        dz;
        logic        ovf;
        int          acc;
    } exp_t;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] din0;
    logic [13:0] din1;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] quot;
    logic [13:0] rem;
    logic        dz;
    logic        ovf;

    exp_t scb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   bp_mode = 0;
    bit   seen = 0;
    bit   check_idle = 0;
    int   held = 0;

    cnn_div_seq_24s_14s #(.ID(1), .DIVIDEND_W(24), .DIVISOR_W(14)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .din0     (din0),
        .din1     (din1),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quot     (quot),
        .rem      (rem),
        .dz       (dz),
        .ovf      (ovf)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain signed division plus the saturation / divide-by-zero rules
    function automatic exp_t model(input logic [23:0] a, input logic [13:0] b, input int acc);
        exp_t   e;
        longint sa, sd, q, r;
        sa    = longint'($signed(a));
        sd    = longint'($signed(b));
        e.acc = acc;
        e.dz  = 1'b0;
        e.ovf = 1'b0;
        if (sd == 0) begin
            e.dz = 1'b1;
            e.r  = '0;
            e.q  = (sa >= 0) ? 24'h7FFFFF : 24'h800000;
        end else begin
            q = sa / sd;
            r = sa % sd;
            if (q > 64'sd8388607) begin
                e.ovf = 1'b1;
                e.q   = 24'h7FFFFF;
                e.r   = '0;
            end else begin
                e.q = 24'(q);
                e.r = 14'(r);
            end
        end
        return e;
    endfunction

    task automatic do_op(input logic [23:0] a, input logic [13:0] b, input bit keep);
        int n;
        n = 0;
        @(negedge ap_clk);
        while (!in_ready && n < 200) begin
            @(negedge ap_clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
            return;
        end
        in_valid = 1'b1;
        din0     = a;
        din1     = b;
        if (keep) scb.push_back(model(a, b, cyc));
        @(negedge ap_clk);
        in_valid = 1'b0;
        din0     = 24'($urandom);
        din1     = 14'($urandom);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (scb.size() != 0 && n < 500) begin
            @(negedge ap_clk);
            n++;
        end
        if (scb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d results still pending", scb.size());
            scb.delete();
        end
        @(negedge ap_clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_quot"}, 32'(quot), 32'd0);
        chk({tag, "_rem"}, 32'(rem), 32'd0);
        chk({tag, "_dz"}, 32'(dz), 32'd0);
        chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    endtask

    function automatic logic [23:0] rand_a();
        case ($urandom_range(0, 7))
            0:       return 24'h800000;
            1:       return 24'h7FFFFF;
            2:       return 24'($signed($urandom_range(0, 40)) - 20);
            default: return 24'($urandom);
        endcase
    endfunction

    function automatic logic [13:0] rand_b();
        case ($urandom_range(0, 9))
            0:       return 14'h0000;
            1:       return 14'h2000;
            2:       return 14'h1FFF;
            3:       return 14'h3FFF;
            4:       return 14'h0001;
            5:       return 14'($signed($urandom_range(0, 16)) - 8);
            default: return 14'($urandom);
        endcase
    endfunction

    // Monitor: compares every presented result against the scoreboard head
    initial begin
        exp_t e;
        bit   rdy;
        out_ready = 1'b0;
        forever begin
            @(negedge ap_clk);
            if (!ap_rst_n) begin
                seen       = 0;
                check_idle = 0;
                out_ready  = 1'b0;
            end else begin
                if (check_idle) begin
                    chk("idle_in_ready", 32'(in_ready), 32'd1);
                    chk("idle_out_valid", 32'(out_valid), 32'd0);
                    check_idle = 0;
                end
                if (out_valid) begin
                    if (scb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_result: quot=0x%0h rem=0x%0h", quot, rem);
                        out_ready = 1'b1;
                    end else begin
                        e = scb[0];
                        if (!seen) begin
                            chk("latency", 32'(cyc - e.acc), 32'(LATENCY));
                            chk("quot", 32'(quot), 32'(e.q));
                            chk("rem", 32'(rem), 32'(e.r));
                            chk("dz", 32'(dz), 32'(e.dz));
                            chk("ovf", 32'(ovf), 32'(e.ovf));
                            seen = 1;
                            held = 0;
                        end else begin
                            chk("hold_quot", 32'(quot), 32'(e.q));
                            chk("hold_rem", 32'(rem), 32'(e.r));
                            chk("hold_flags", 32'({dz, ovf}), 32'({e.dz, e.ovf}));
                        end
                        chk("no_overlap_in_ready", 32'(in_ready), 32'd0);
                        case (bp_mode)
                            1:       rdy = ($urandom_range(0, 3) != 0);
                            2:       rdy = (held >= 10);
                            default: rdy = 1'b1;
                        endcase
                        held++;
                        out_ready = rdy;
                        if (rdy) begin
                            void'(scb.pop_front());
                            seen       = 0;
                            check_idle = 1;
                        end
                    end
                end else begin
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    initial begin
        ap_rst_n = 1'b1;
        in_valid = 1'b0;
        din0     = '0;
        din1     = '0;
        #2 ap_rst_n = 1'b0;
        #1 check_reset_outputs("por");
        repeat (3) @(negedge ap_clk);
        check_reset_outputs("por_held");
        ap_rst_n = 1'b1;

        bp_mode = 0;
        do_op(24'd1000, 14'd7, 1);
        do_op(-24'sd1000, 14'd7, 1);
        do_op(24'd1000, -14'sd7, 1);
        do_op(24'h800000, 14'h3FFF, 1);
        do_op(-24'sd5, 14'd0, 1);
        do_op(24'd5, 14'd0, 1);
        do_op(24'h800000, 14'h2000, 1);
        do_op(-24'sd14, 14'd7, 1);
        wait_drain();

        bp_mode = 2;
        do_op(24'd1000, 14'd7, 1);
        wait_drain();
        bp_mode = 0;

        // abort mid-CALC: nothing is pushed, so any output would be flagged
        do_op(24'd123456, 14'd77, 0);
        repeat (11) @(negedge ap_clk);
        #2 ap_rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        do_op(24'h7FFFFF, 14'h2000, 1);
        wait_drain();

        bp_mode = 1;
        for (int i = 0; i < N_RAND; i++) begin
            if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) @(negedge ap_clk);
            do_op(rand_a(), rand_b(), 1);
        end
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
